player_laser: RTL and testbench
===============================

# player_laser

Single-shot laser controller for the player ship, directly downstream of `player`. It consumes the centre-button shoot request, the ship's gun position and the frame strobe. It launches one laser at a time from the gun, moves it upward once per frame, and retires it on a target hit or at the top border. A frame-counted cooldown follows each retirement. Its outputs feed the collision logic and the display mixer.

## Interface
- `color_p`, `{4'hF,4'hF,4'hF}`: laser colour, `{Red,Green,Blue}`.
- `spawn_y_p`, `10'd440`: laser top y at launch.
- `top_border_p`, `10'd8`: smallest legal laser top y.
- `step_p`, `10'd8`: pixels moved upward per frame.
- `length_p`, `10'd12`: laser height in pixels.
- `cooldown_p`, `4'd15`: frames in COOLDOWN after retirement; 0 means no cooldown.
- `clk_i` input 1: clock.
- `reset_i` input 1: reset; synchronous, active-high. One clock; no other reset exists.
- `shoot_i` input 1: centre button level.
- `frame_i` input 1: one-cycle pulse per video frame.
- `gun_pos_i` input 10: ship gun x (`player.gun_pos_o`).
- `alive_i` input 1: player alive (`player.alive_o`).
- `freeze_i` input 1: game paused (player hit / level transition); holds all state.
- `target_hit_i` input 1: collision logic reports the laser struck an enemy or shield.
- `laser_active_o` output 1: laser on screen.
- `laser_x_o` output 10: laser x (latched gun position).
- `laser_top_o` output 10: laser top y.
- `laser_bottom_o` output 10: `laser_top_o + length_p - 1`, 10-bit wrap.
- `fired_o` output 1: one-cycle pulse on launch.
- `laser_red_o`, `laser_green_o`, `laser_blue_o` output 4 each: `color_p` nibbles.
- `state_o` output 2: present state, for debug.

## Operation
- States: IDLE=2'b00, FLYING=2'b01, COOLDOWN=2'b10. 2'b11 is illegal and returns to IDLE on the next cycle.
- Edge detect: `shoot_q` is registered every cycle, in all states, including during freeze. `fire_req = shoot_i & ~shoot_q`. A held button never refires.
- IDLE to FLYING: requires `fire_req & alive_i & ~freeze_i`. On that edge:
  - `laser_x` <= `gun_pos_i`.
  - `laser_top` <= `spawn_y_p`.
  - `fired_o` <= 1.
- FLYING, priority order:
  1. `~alive_i` moves to IDLE.
  2. `freeze_i` holds state.
  3. `target_hit_i` moves to COOLDOWN, with or without a frame.
  4. On `frame_i`: if `laser_top < top_border_p + step_p`, move to COOLDOWN. Otherwise `laser_top` <= `laser_top - step_p`.
- Entering COOLDOWN loads `cd_cnt` <= `cooldown_p`. If `cooldown_p == 0`, go straight to IDLE instead.
- COOLDOWN:
  - `~alive_i` moves to IDLE.
  - `freeze_i` holds.
  - On `frame_i`: if `cd_cnt == 1`, move to IDLE; else `cd_cnt` decrements.
  - `fire_req` is ignored.
- Entering IDLE: `laser_top` <= `spawn_y_p`, `cd_cnt` <= 0. `laser_x` holds.
- `laser_active_o` = (state == FLYING).
- `fired_o` is high exactly one cycle per launch.
- Colour outputs are constant.
- `laser_top` never underflows: the miss check runs before the subtraction.

## Timing
- Reset values:
  - state IDLE, `state_o` 2'b00.
  - `laser_active_o` 0, `fired_o` 0.
  - `laser_x_o` 0, `laser_top_o` `spawn_y_p`, `laser_bottom_o` `spawn_y_p + length_p - 1`.
  - `shoot_q` 0, `cd_cnt` 0.
- Reset mid-flight clears everything on the next edge.
- Launch latency: `fire_req` sampled at edge N. `laser_active_o` and `fired_o` are high after edge N, with `laser_top_o` = `spawn_y_p`.
- First movement happens on the first `frame_i` after launch, not in the launch cycle.
- `target_hit_i` in FLYING: `laser_active_o` drops after the same edge.
- Cooldown length is exactly `cooldown_p` `frame_i` pulses (frozen frames excluded). IDLE is entered on the edge of the last pulse.
- Simultaneous `target_hit_i` and `frame_i`: the hit wins and `laser_top` does not move.
- Simultaneous `fire_req` and `freeze_i`: no launch. The edge is consumed and does not fire after unfreeze.
- `gun_pos_i` changes after launch do not affect `laser_x_o`.

## Test plan
- Reset, then `shoot_i` 0→1 with `gun_pos_i`=139 and `alive_i`=1 → next cycle `laser_active_o`=1, `fired_o`=1 for one cycle, `laser_x_o`=139, `laser_top_o`=440, `laser_bottom_o`=451.
- Launch, then 54 frame pulses → `laser_top_o`=8. The 55th frame retires the laser (active=0, state 2'b10). After 15 more frames the state is 2'b00.
- FLYING at `laser_top_o`=400, `target_hit_i` and `frame_i` in the same cycle → active=0, `laser_top_o` stays 400, state COOLDOWN.
- Hold `shoot_i`=1 through the whole flight and cooldown → no second launch. Release, then press → launch.
- FLYING at 320, `freeze_i`=1 for 10 frames → `laser_top_o` stays 320. Unfreeze, one frame → 312. `alive_i`=0 → next cycle state IDLE, active=0.
- `cooldown_p`=0, target hit → IDLE next cycle. A new press launches one cycle after that.

Source files
------------

// File: rtl/player_laser.sv
// player_laser
// Single-shot laser controller for the player ship. A rising edge on the
// centre button launches one laser from the ship's gun position. The laser
// climbs step_p pixels per video frame. It is retired by a target hit or
// at the top border, and a frame-counted cooldown then blocks the next
// shot.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   shoot_i                 centre button level
//   frame_i                 one-cycle pulse per video frame
//   gun_pos_i[9:0]          ship gun x, latched at launch
//   alive_i                 player alive; when low the laser is dropped
//   freeze_i                game paused; all state except the button history holds
//   target_hit_i            collision logic reports a hit on the laser
//   laser_active_o          laser on screen (state FLYING)
//   laser_x_o[9:0]          latched laser x
//   laser_top_o[9:0]        laser top y
//   laser_bottom_o[9:0]     laser_top_o + length_p - 1 (10-bit wrap)
//   fired_o                 one-cycle pulse per launch
//   laser_{red,green,blue}_o  constant laser colour nibbles
//   state_o[1:0]            present state, for debug
module player_laser #(
    parameter logic [11:0] color_p      = {4'hF, 4'hF, 4'hF},
    parameter logic [9:0]  spawn_y_p    = 10'd440,
    parameter logic [9:0]  top_border_p = 10'd8,
    parameter logic [9:0]  step_p       = 10'd8,
    parameter logic [9:0]  length_p     = 10'd12,
    parameter logic [3:0]  cooldown_p   = 4'd15
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       shoot_i,
    input  logic       frame_i,
    input  logic [9:0] gun_pos_i,
    input  logic       alive_i,
    input  logic       freeze_i,
    input  logic       target_hit_i,
    output logic       laser_active_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_top_o,
    output logic [9:0] laser_bottom_o,
    output logic       fired_o,
    output logic [3:0] laser_red_o,
    output logic [3:0] laser_green_o,
    output logic [3:0] laser_blue_o,
    output logic [1:0] state_o
);

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] FLYING   = 2'b01;
    localparam logic [1:0] COOLDOWN = 2'b10;

    logic [1:0] state_q, state_d;
    logic [9:0] laser_x_q, laser_x_d;
    logic [9:0] laser_top_q, laser_top_d;
    logic [3:0] cd_cnt_q, cd_cnt_d;
    logic       fired_q, fired_d;
    logic       shoot_q;
    logic       fire_req;
    logic       enter_idle;
    logic       enter_cool;

    // Next-state logic. Individual branches only raise enter_idle/enter_cool;
    // the shared entry actions for those states are applied once at the end.
    // A zero cooldown turns a retirement straight into an IDLE entry.
    always_comb begin
        fire_req    = shoot_i & ~shoot_q;
        state_d     = state_q;
        laser_x_d   = laser_x_q;
        laser_top_d = laser_top_q;
        cd_cnt_d    = cd_cnt_q;
        fired_d     = 1'b0;
        enter_idle  = 1'b0;
        enter_cool  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire_req && alive_i && !freeze_i) begin
                    state_d     = FLYING;
                    laser_x_d   = gun_pos_i;
                    laser_top_d = spawn_y_p;
                    fired_d     = 1'b1;
                end
            end
            FLYING: begin
                if (!alive_i) begin
                    enter_idle = 1'b1;
                end else if (!freeze_i) begin
                    if (target_hit_i) begin
                        enter_cool = 1'b1;
                    end else if (frame_i) begin
                        // The miss check comes before the subtraction, so the top never underflows
                        if (laser_top_q < top_border_p + step_p) begin
                            enter_cool = 1'b1;
                        end else begin
                            laser_top_d = laser_top_q - step_p;
                        end
                    end
                end
            end
            COOLDOWN: begin
                if (!alive_i) begin
                    enter_idle = 1'b1;
                end else if (!freeze_i && frame_i) begin
                    if (cd_cnt_q == 4'd1) begin
                        enter_idle = 1'b1;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                enter_idle = 1'b1;
            end
        endcase

        if (enter_cool) begin
            if (cooldown_p == 4'd0) begin
                enter_idle = 1'b1;
            end else begin
                state_d  = COOLDOWN;
                cd_cnt_d = cooldown_p;
            end
        end

        if (enter_idle) begin
            state_d     = IDLE;
            laser_top_d = spawn_y_p;
            cd_cnt_d    = 4'd0;
        end
    end

    // State registers. shoot_q samples the button every cycle, even while frozen,
    // so an edge that arrives during a freeze is consumed rather than deferred.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            laser_x_q   <= 10'd0;
            laser_top_q <= spawn_y_p;
            cd_cnt_q    <= 4'd0;
            fired_q     <= 1'b0;
            shoot_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            laser_x_q   <= laser_x_d;
            laser_top_q <= laser_top_d;
            cd_cnt_q    <= cd_cnt_d;
            fired_q     <= fired_d;
            shoot_q     <= shoot_i;
        end
    end

    assign laser_active_o = (state_q == FLYING);
    assign laser_x_o      = laser_x_q;
    assign laser_top_o    = laser_top_q;
    assign laser_bottom_o = laser_top_q + length_p - 10'd1;
    assign fired_o        = fired_q;
    assign state_o        = state_q;
    assign laser_red_o    = color_p[11:8];
    assign laser_green_o  = color_p[7:4];
    assign laser_blue_o   = color_p[3:0];

endmodule

// File: tb/tb_player_laser.sv
// tb_player_laser
// Drives two player_laser instances from the same stimulus: one with the
// default 15-frame cooldown and one with no cooldown. Each instance is
// compared every cycle against a frame-counting reference model. A directed
// walk through the key scenarios comes first, followed by a randomized run.
module tb_player_laser;

    logic       clk = 1'b0;
    logic       resetI = 1'b1;
    logic       shootI = 1'b0;
    logic       frameI = 1'b0;
    logic [9:0] gunPosI = 10'd0;
    logic       aliveI = 1'b1;
    logic       freezeI = 1'b0;
    logic       hitI = 1'b0;

    logic       aActive, bActive, aFired, bFired;
    logic [9:0] aX, aTop, aBottom, bX, bTop, bBottom;
    logic [3:0] aRed, aGreen, aBlue, bRed, bGreen, bBlue;
    logic [1:0] aState, bState;

    int errors = 0;
    int checks = 0;

    // Reference model, per instance: mode 0 idle / 1 flying / 2 cooldown.
    // Height is derived from the number of frames flown since launch.
    int mode[2];
    int flown[2];
    int coolLeft[2];
    int modelX[2];
    int prevShoot[2];
    int expFired[2];
    int coolFrames[2] = '{15, 0};

    player_laser dutA (
        .clk_i(clk), .reset_i(resetI), .shoot_i(shootI), .frame_i(frameI),
        .gun_pos_i(gunPosI), .alive_i(aliveI), .freeze_i(freezeI), .target_hit_i(hitI),
        .laser_active_o(aActive), .laser_x_o(aX), .laser_top_o(aTop), .laser_bottom_o(aBottom),
        .fired_o(aFired), .laser_red_o(aRed), .laser_green_o(aGreen), .laser_blue_o(aBlue),
        .state_o(aState)
    );

    player_laser #(.cooldown_p(4'd0)) dutB (
        .clk_i(clk), .reset_i(resetI), .shoot_i(shootI), .frame_i(frameI),
        .gun_pos_i(gunPosI), .alive_i(aliveI), .freeze_i(freezeI), .target_hit_i(hitI),
        .laser_active_o(bActive), .laser_x_o(bX), .laser_top_o(bTop), .laser_bottom_o(bBottom),
        .fired_o(bFired), .laser_red_o(bRed), .laser_green_o(bGreen), .laser_blue_o(bBlue),
        .state_o(bState)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench goes through here
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int expTop(input int k);
        return (mode[k] == 0) ? 440 : 440 - 8 * flown[k];
    endfunction

    task automatic retire(input int k);
        if (coolFrames[k] == 0) begin
            mode[k] = 0;
            flown[k] = 0;
        end else begin
            mode[k] = 2;
            coolLeft[k] = coolFrames[k];
        end
    endtask

    // Advance the model by one clock edge, using the inputs seen at that edge
    task automatic modelStep(input int k);
        bit fireReq;
        fireReq = shootI && (prevShoot[k] == 0);
        prevShoot[k] = shootI ? 1 : 0;
        expFired[k] = 0;
        if (resetI) begin
            mode[k] = 0; flown[k] = 0; coolLeft[k] = 0; modelX[k] = 0; prevShoot[k] = 0;
            return;
        end
        case (mode[k])
            0: if (fireReq && aliveI && !freezeI) begin
                mode[k] = 1; flown[k] = 0; modelX[k] = int'(gunPosI); expFired[k] = 1;
            end
            1: if (!aliveI) begin
                mode[k] = 0; flown[k] = 0;
            end else if (!freezeI) begin
                if (hitI) retire(k);
                else if (frameI) begin
                    if (expTop(k) < 16) retire(k);
                    else flown[k]++;
                end
            end
            default: if (!aliveI) begin
                mode[k] = 0; flown[k] = 0;
            end else if (!freezeI && frameI) begin
                coolLeft[k]--;
                if (coolLeft[k] == 0) begin
                    mode[k] = 0; flown[k] = 0;
                end
            end
        endcase
    endtask

    task automatic checkSet(input string n, input int k, input logic act, input logic [9:0] x,
                            input logic [9:0] top, input logic [9:0] bot, input logic fired,
                            input logic [1:0] st, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        checkOutput({n, ".active"}, 32'(act), (mode[k] == 1) ? 1 : 0);
        checkOutput({n, ".x"}, 32'(x), modelX[k]);
        checkOutput({n, ".top"}, 32'(top), expTop(k));
        checkOutput({n, ".bottom"}, 32'(bot), (expTop(k) + 11) % 1024);
        checkOutput({n, ".fired"}, 32'(fired), expFired[k]);
        checkOutput({n, ".state"}, 32'(st), mode[k]);
        checkOutput({n, ".colour"}, {20'd0, r, g, b}, 32'hFFF);
    endtask

    task automatic checkAll();
        checkSet("a", 0, aActive, aX, aTop, aBottom, aFired, aState, aRed, aGreen, aBlue);
        checkSet("b", 1, bActive, bX, bTop, bBottom, bFired, bState, bRed, bGreen, bBlue);
    endtask

    // Drive one cycle of inputs, clock it, update the model, then check just after the edge
    task automatic applyStimulus(input logic shoot, input logic frame, input logic [9:0] gun,
                                 input logic alive, input logic freeze, input logic hit);
        shootI = shoot; frameI = frame; gunPosI = gun; aliveI = alive; freezeI = freeze; hitI = hit;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkAll();
    endtask

    task automatic resetDut();
        resetI = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        resetI = 1'b0;
    endtask

    // n frame pulses, each followed by an idle cycle
    task automatic pulseFrames(input int n, input logic shoot, input logic freeze);
        for (int i = 0; i < n; i++) begin
            applyStimulus(shoot, 1'b1, 10'($urandom_range(0, 1023)), 1'b1, freeze, 1'b0);
            applyStimulus(shoot, 1'b0, 10'($urandom_range(0, 1023)), 1'b1, freeze, 1'b0);
        end
    endtask

    task automatic launch(input logic [9:0] gun);
        applyStimulus(1'b0, 1'b0, gun, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, gun, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] player_laser bench start");
        resetDut();
        checkOutput("resetTop", 32'(aTop), 440);
        checkOutput("resetBottom", 32'(aBottom), 451);

        // Launch from x=139 and fly all the way to the top border
        launch(10'd139);
        checkOutput("launchX", 32'(aX), 139);
        checkOutput("launchFired", 32'(aFired), 1);
        checkOutput("launchBottom", 32'(aBottom), 451);
        applyStimulus(1'b0, 1'b0, 10'd500, 1'b1, 1'b0, 1'b0);
        checkOutput("firedOneCycle", 32'(aFired), 0);
        pulseFrames(54, 1'b0, 1'b0);
        checkOutput("topAtBorder", 32'(aTop), 8);
        checkOutput("gunIgnored", 32'(aX), 139);
        pulseFrames(1, 1'b0, 1'b0);
        checkOutput("missRetire", 32'(aState), 2);
        pulseFrames(14, 1'b0, 1'b0);
        checkOutput("coolNotDone", 32'(aState), 2);
        pulseFrames(1, 1'b0, 1'b0);
        checkOutput("coolDone", 32'(aState), 0);

        // Hit together with a frame at height 400: the hit wins
        launch(10'd77);
        pulseFrames(5, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'd3, 1'b1, 1'b0, 1'b1);
        checkOutput("hitTop", 32'(aTop), 400);
        checkOutput("hitState", 32'(aState), 2);
        checkOutput("hitNoCoolB", 32'(bState), 0);

        // Button held through the rest of cooldown: no refire, then release and press
        pulseFrames(20, 1'b1, 1'b0);
        checkOutput("heldNoLaunch", 32'(aActive), 0);
        launch(10'd600);
        checkOutput("relaunch", 32'(aFired), 1);

        // Freeze at height 320, then unfreeze, then lose the player
        pulseFrames(15, 1'b0, 1'b0);
        checkOutput("top320", 32'(aTop), 320);
        applyStimulus(1'b1, 1'b0, 10'd1, 1'b1, 1'b1, 1'b1);
        pulseFrames(10, 1'b0, 1'b1);
        checkOutput("frozenTop", 32'(aTop), 320);
        pulseFrames(1, 1'b0, 1'b0);
        checkOutput("unfrozenTop", 32'(aTop), 312);
        applyStimulus(1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("deadIdle", 32'(aState), 0);

        // Press during freeze is consumed and never fires later
        applyStimulus(1'b1, 1'b0, 10'd9, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("freezePressLost", 32'(aActive), 0);

        // Reset in flight
        launch(10'd250);
        pulseFrames(3, 1'b0, 1'b0);
        resetDut();
        checkOutput("midResetX", 32'(aX), 0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? ~shootI : shootI,
                          $urandom_range(0, 3) == 0,
                          10'($urandom_range(0, 1023)),
                          $urandom_range(0, 59) != 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
